dcache_load_responder: RTL and testbench

DCACHE_LOAD_RESPONDER -- requirements
Module: dcache_load_responder

---
 rtl/dcache_load_responder.sv | 195 +++++++++++++++++++
 tb/tb_dcache_load_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_load_responder.sv
// dcache_load_responder: direct-mapped, load-only data cache that answers hits in the lookup cycle and tracks misses in MSHRs
package dcache_load_responder_pkg;
    localparam int NUM_LU_DCACHE = 2;
    localparam int N = 2;
    localparam int LQ_IDX_W = 3;
    typedef logic [31:0] ADDR;
    typedef logic [31:0] DATA;
    typedef logic [3:0] MEM_TAG;
    typedef logic [63:0] MEM_BLOCK;
    typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} BUS_COMMAND;
    typedef struct packed {
        logic                valid;
        logic [LQ_IDX_W-1:0] lq_idx;
        ADDR                 addr;
        logic [2:0]          mem_func;
    } LQ_DCACHE_PACKET;
    typedef struct packed {
        logic                valid;
        logic [LQ_IDX_W-1:0] lq_idx;
        DATA                 data;
    } DCACHE_LQ_PACKET;
endpackage

module dcache_load_responder
    import dcache_load_responder_pkg::*;
#(
    parameter int DCACHE_LINES = 32,
    parameter int NUM_MSHR = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  LQ_DCACHE_PACKET               lq_dcache_packet [NUM_LU_DCACHE],
    output logic [NUM_LU_DCACHE-1:0]      load_req_accept,
    output logic [NUM_LU_DCACHE-1:0]      load_req_data_valid,
    output DATA                           load_req_data [NUM_LU_DCACHE],
    output DCACHE_LQ_PACKET               dcache_lq_packet [N],
    output BUS_COMMAND                    proc2mem_command,
    output ADDR                           proc2mem_addr,
    input  MEM_TAG                        mem2proc_transaction_tag,
    input  MEM_BLOCK                      mem2proc_data,
    input  MEM_TAG                        mem2proc_data_tag
);
    localparam int IDX_W = $clog2(DCACHE_LINES);
    localparam int TAG_W = 29 - IDX_W;
    localparam int MW = NUM_MSHR > 1 ? $clog2(NUM_MSHR) : 1;
    localparam int PW = NUM_LU_DCACHE > 1 ? $clog2(NUM_LU_DCACHE) : 1;

    typedef enum logic [1:0] {FREE, ISSUE, WAIT_DATA, RESPOND} mshr_state_t;

    logic [DCACHE_LINES-1:0] line_valid;
    logic [TAG_W-1:0]        line_tag [DCACHE_LINES];
    MEM_BLOCK                line_data [DCACHE_LINES];

    mshr_state_t         mshr_state [NUM_MSHR];
    mshr_state_t         mshr_next [NUM_MSHR];
    logic [LQ_IDX_W-1:0] mshr_lq_idx [NUM_MSHR];
    logic [28:0]         mshr_line [NUM_MSHR];
    logic                mshr_word_sel [NUM_MSHR];
    MEM_TAG              mshr_tag [NUM_MSHR];
    DATA                 mshr_word [NUM_MSHR];

    logic [NUM_MSHR-1:0] alloc;
    logic [PW-1:0]       alloc_port [NUM_MSHR];
    logic                issue_any;
    logic [MW-1:0]       issue_sel;
    logic                fill_any;
    logic [MW-1:0]       fill_sel;
    logic                unused_bits;

    // Per-port lookup; misses claim the lowest free MSHR, lower ports first, and a line already in flight is refused
    always_comb begin
        logic [NUM_LU_DCACHE-1:0] acc;
        logic [NUM_LU_DCACHE-1:0] dv;
        logic [28:0]              line;
        logic [IDX_W-1:0]         idx;
        logic                     hit;
        logic                     pending;
        logic                     placed;
        acc = '0;
        dv = '0;
        line = '0;
        idx = '0;
        hit = 1'b0;
        pending = 1'b0;
        placed = 1'b0;
        alloc = '0;
        for (int m = 0; m < NUM_MSHR; m++) alloc_port[m] = '0;
        for (int p = 0; p < NUM_LU_DCACHE; p++) begin
            line = lq_dcache_packet[p].addr[31:3];
            idx = line[IDX_W-1:0];
            hit = lq_dcache_packet[p].valid && line_valid[idx] && line_tag[idx] == line[28:IDX_W];
            pending = 1'b0;
            for (int m = 0; m < NUM_MSHR; m++)
                if (mshr_state[m] != FREE && mshr_line[m] == line) pending = 1'b1;
            for (int q = 0; q < NUM_LU_DCACHE; q++)
                if (q < p && acc[q] && !dv[q] && lq_dcache_packet[q].addr[31:3] == line) pending = 1'b1;
            placed = 1'b0;
            if (lq_dcache_packet[p].valid && !hit && !pending)
                for (int m = 0; m < NUM_MSHR; m++)
                    if (!placed && mshr_state[m] == FREE && !alloc[m]) begin
                        alloc[m] = 1'b1;
                        alloc_port[m] = PW'(p);
                        placed = 1'b1;
                    end
            acc[p] = hit || placed;
            dv[p] = hit;
            load_req_data[p] = hit ? (lq_dcache_packet[p].addr[2] ? line_data[idx][63:32] : line_data[idx][31:0]) : '0;
        end
        load_req_accept = acc;
        load_req_data_valid = dv;
    end

    // Bus issue arbitration, fill match, completion output and MSHR next state
    always_comb begin
        issue_any = 1'b0;
        issue_sel = '0;
        fill_any = 1'b0;
        fill_sel = '0;
        proc2mem_command = BUS_NONE;
        proc2mem_addr = '0;
        for (int n = 0; n < N; n++) dcache_lq_packet[n] = '0;
        for (int m = NUM_MSHR - 1; m >= 0; m--) begin
            if (mshr_state[m] == ISSUE) begin
                issue_any = 1'b1;
                issue_sel = MW'(m);
            end
            if (mshr_state[m] == WAIT_DATA && mem2proc_data_tag != '0 && mshr_tag[m] == mem2proc_data_tag) begin
                fill_any = 1'b1;
                fill_sel = MW'(m);
            end
            if (mshr_state[m] == RESPOND) dcache_lq_packet[0] = {1'b1, mshr_lq_idx[m], mshr_word[m]};
        end
        if (issue_any) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr = {mshr_line[issue_sel], 3'b000};
        end
        for (int m = 0; m < NUM_MSHR; m++) begin
            mshr_next[m] = mshr_state[m];
            case (mshr_state[m])
                FREE:      mshr_next[m] = alloc[m] ? ISSUE : FREE;
                ISSUE:     mshr_next[m] = (issue_sel == MW'(m) && mem2proc_transaction_tag != '0) ? WAIT_DATA : ISSUE;
                WAIT_DATA: mshr_next[m] = (fill_any && fill_sel == MW'(m)) ? RESPOND : WAIT_DATA;
                RESPOND:   mshr_next[m] = FREE;
                default:   mshr_next[m] = FREE;
            endcase
        end
    end

    // MSHR state register plus request capture, bus tag recording and word latch on fill
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < NUM_MSHR; m++) begin
                mshr_state[m] <= FREE;
                mshr_lq_idx[m] <= '0;
                mshr_line[m] <= '0;
                mshr_word_sel[m] <= 1'b0;
                mshr_tag[m] <= '0;
                mshr_word[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_MSHR; m++) begin
                mshr_state[m] <= mshr_next[m];
                if (alloc[m]) begin
                    mshr_lq_idx[m] <= lq_dcache_packet[alloc_port[m]].lq_idx;
                    mshr_line[m] <= lq_dcache_packet[alloc_port[m]].addr[31:3];
                    mshr_word_sel[m] <= lq_dcache_packet[alloc_port[m]].addr[2];
                end
                if (mshr_state[m] == ISSUE && mshr_next[m] == WAIT_DATA) mshr_tag[m] <= mem2proc_transaction_tag;
                if (mshr_state[m] == WAIT_DATA && mshr_next[m] == RESPOND)
                    mshr_word[m] <= mshr_word_sel[m] ? mem2proc_data[63:32] : mem2proc_data[31:0];
            end
        end
    end

    // Line valid bits, set by a fill and cleared by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) line_valid <= '0;
        else if (fill_any) line_valid[mshr_line[fill_sel][IDX_W-1:0]] <= 1'b1;
    end

    // Tag and data storage, overwritten unconditionally by a fill
    always_ff @(posedge clock) begin
        if (fill_any) begin
            line_tag[mshr_line[fill_sel][IDX_W-1:0]] <= mshr_line[fill_sel][28:IDX_W];
            line_data[mshr_line[fill_sel][IDX_W-1:0]] <= mem2proc_data;
        end
    end

    // Byte offset and access size are resolved by the load queue, not here
    always_comb begin
        unused_bits = 1'b0;
        for (int p = 0; p < NUM_LU_DCACHE; p++)
            unused_bits = unused_bits ^ (^{lq_dcache_packet[p].addr[1:0], lq_dcache_packet[p].mem_func});
    end
endmodule

// File: tb/tb_dcache_load_responder.sv
// tb_dcache_load_responder: directed scenario bench for the load responder cache
module tb_dcache_load_responder;
    import dcache_load_responder_pkg::*;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    LQ_DCACHE_PACKET          req [NUM_LU_DCACHE];
    logic [NUM_LU_DCACHE-1:0] accept;
    logic [NUM_LU_DCACHE-1:0] data_valid;
    DATA                      rdata [NUM_LU_DCACHE];
    DCACHE_LQ_PACKET          resp [N];
    BUS_COMMAND               cmd;
    ADDR                      maddr;
    MEM_TAG                   ttag = '0;
    MEM_TAG                   dtag = '0;
    MEM_BLOCK                 mdata = '0;
    DCACHE_LQ_PACKET          exp_resp;
    int                       checks = 0;
    int                       errors = 0;

    always #5 clock = ~clock;

    dcache_load_responder #(.DCACHE_LINES(32), .NUM_MSHR(4)) dut (
        .clock(clock),
        .reset(reset),
        .lq_dcache_packet(req),
        .load_req_accept(accept),
        .load_req_data_valid(data_valid),
        .load_req_data(rdata),
        .dcache_lq_packet(resp),
        .proc2mem_command(cmd),
        .proc2mem_addr(maddr),
        .mem2proc_transaction_tag(ttag),
        .mem2proc_data(mdata),
        .mem2proc_data_tag(dtag)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        for (int p = 0; p < NUM_LU_DCACHE; p++) req[p] = '0;
        ttag = '0;
        dtag = '0;
        mdata = '0;
    endtask

    task automatic load(input int p, input logic [2:0] idx, input ADDR a);
        req[p] = '{valid: 1'b1, lq_idx: idx, addr: a, mem_func: 3'b010};
    endtask

    task automatic test_reset();
        idle();
        tick();
        tick();
        #3;
        checks++; if (accept !== 2'b00) begin errors++; $display("FAIL reset_accept got %b want 00", accept); end
        checks++; if (data_valid !== 2'b00) begin errors++; $display("FAIL reset_data_valid got %b want 00", data_valid); end
        checks++; if (resp[0].valid !== 1'b0 || resp[1].valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b%b want 00", resp[1].valid, resp[0].valid); end
        checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL reset_cmd got %0d want %0d", cmd, BUS_NONE); end
        checks++; if (maddr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", maddr); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        tick(); load(0, 3'd1, 32'h104); #3;
        checks++; if (accept !== 2'b01) begin errors++; $display("FAIL cold_accept got %b want 01", accept); end
        checks++; if (data_valid !== 2'b00) begin errors++; $display("FAIL cold_data_valid got %b want 00", data_valid); end
        tick(); idle(); ttag = 4'd3; #3;
        checks++; if (cmd !== BUS_LOAD) begin errors++; $display("FAIL cold_cmd got %0d want %0d", cmd, BUS_LOAD); end
        checks++; if (maddr !== 32'h100) begin errors++; $display("FAIL cold_addr got %h want 00000100", maddr); end
        tick(); ttag = '0; #3;
        checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL cold_cmd_after got %0d want %0d", cmd, BUS_NONE); end
        tick(); dtag = 4'd3; mdata = 64'hAABBCCDD_11223344; load(1, 3'd2, 32'h100); #3;
        checks++; if (resp[0].valid !== 1'b0) begin errors++; $display("FAIL cold_resp_early got %b want 0", resp[0].valid); end
        checks++; if (accept !== 2'b00 || data_valid !== 2'b00) begin errors++; $display("FAIL fill_cycle_lookup got acc %b dv %b want 00 00", accept, data_valid); end
        tick(); idle(); #3;
        exp_resp = '{valid: 1'b1, lq_idx: 3'd1, data: 32'hAABBCCDD};
        checks++; if (resp[0] !== exp_resp) begin errors++; $display("FAIL cold_resp got %h want %h", resp[0], exp_resp); end
        checks++; if (resp[1].valid !== 1'b0) begin errors++; $display("FAIL cold_resp1 got %b want 0", resp[1].valid); end
        tick(); #3;
        checks++; if (resp[0].valid !== 1'b0) begin errors++; $display("FAIL cold_resp_once got %b want 0", resp[0].valid); end
    endtask

    task automatic test_hit();
        tick(); load(0, 3'd4, 32'h100); #3;
        checks++; if (accept !== 2'b01 || data_valid !== 2'b01) begin errors++; $display("FAIL hit_flags got acc %b dv %b want 01 01", accept, data_valid); end
        checks++; if (rdata[0] !== 32'h11223344) begin errors++; $display("FAIL hit_data got %h want 11223344", rdata[0]); end
        checks++; if (rdata[1] !== 32'h0) begin errors++; $display("FAIL idle_port_data got %h want 0", rdata[1]); end
        tick(); load(0, 3'd4, 32'h104); load(1, 3'd5, 32'h100); #3;
        checks++; if (accept !== 2'b11 || data_valid !== 2'b11) begin errors++; $display("FAIL dual_hit_flags got acc %b dv %b want 11 11", accept, data_valid); end
        checks++; if (rdata[0] !== 32'hAABBCCDD || rdata[1] !== 32'h11223344) begin errors++; $display("FAIL dual_hit_data got %h %h want aabbccdd 11223344", rdata[0], rdata[1]); end
        checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL hit_no_bus got %0d want %0d", cmd, BUS_NONE); end
        tick(); idle();
    endtask

    task automatic test_backpressure();
        tick(); load(0, 3'd2, 32'h308); #3;
        checks++; if (accept !== 2'b01 || data_valid !== 2'b00) begin errors++; $display("FAIL bp_accept got acc %b dv %b want 01 00", accept, data_valid); end
        tick(); idle();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            ttag = (k == 3) ? 4'd5 : 4'd0;
            #3;
            checks++; if (cmd !== BUS_LOAD || maddr !== 32'h308) begin errors++; $display("FAIL bp_hold_%0d got cmd %0d addr %h want %0d 00000308", k, cmd, maddr, BUS_LOAD); end
        end
        tick(); ttag = '0; #3;
        checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL bp_release got %0d want %0d", cmd, BUS_NONE); end
        tick(); dtag = 4'd5; mdata = 64'h55555555_66666666; #3;
        tick(); dtag = '0; #3;
        exp_resp = '{valid: 1'b1, lq_idx: 3'd2, data: 32'h66666666};
        checks++; if (resp[0] !== exp_resp) begin errors++; $display("FAIL bp_resp got %h want %h", resp[0], exp_resp); end
        tick(); load(0, 3'd0, 32'h30C); #3;
        checks++; if (data_valid !== 2'b01 || rdata[0] !== 32'h55555555) begin errors++; $display("FAIL bp_hit got dv %b data %h want 01 55555555", data_valid, rdata[0]); end
        tick(); idle();
    endtask

    task automatic test_mshr_full();
        ADDR         a [5] = '{32'h400, 32'h408, 32'h410, 32'h418, 32'h420};
        ADDR         drain_addr [4] = '{32'h420, 32'h408, 32'h410, 32'h418};
        logic [2:0]  drain_idx [4] = '{3'd7, 3'd4, 3'd5, 3'd6};
        for (int k = 0; k < 4; k++) begin
            tick(); load(0, 3'(3 + k), a[k]); #3;
            checks++; if (accept !== 2'b01) begin errors++; $display("FAIL full_alloc_%0d got %b want 01", k, accept); end
        end
        tick(); load(0, 3'd7, a[4]); #3;
        checks++; if (accept !== 2'b00) begin errors++; $display("FAIL full_reject got %b want 00", accept); end
        tick(); ttag = 4'd7; #3;
        checks++; if (cmd !== BUS_LOAD || maddr !== 32'h400) begin errors++; $display("FAIL full_first_issue got cmd %0d addr %h want %0d 00000400", cmd, maddr, BUS_LOAD); end
        tick(); ttag = '0; dtag = 4'd7; mdata = {32'hD0000000, 32'hC0000000}; #3;
        checks++; if (accept !== 2'b00) begin errors++; $display("FAIL full_fill_reject got %b want 00", accept); end
        tick(); dtag = '0; #3;
        exp_resp = '{valid: 1'b1, lq_idx: 3'd3, data: 32'hC0000000};
        checks++; if (resp[0] !== exp_resp) begin errors++; $display("FAIL full_resp got %h want %h", resp[0], exp_resp); end
        checks++; if (accept !== 2'b00) begin errors++; $display("FAIL full_respond_cycle got %b want 00", accept); end
        tick(); #3;
        checks++; if (accept !== 2'b01) begin errors++; $display("FAIL full_after_free got %b want 01", accept); end
        tick(); idle();
        for (int k = 0; k < 4; k++) begin
            ttag = 4'(8 + k); #3;
            checks++; if (cmd !== BUS_LOAD || maddr !== drain_addr[k]) begin errors++; $display("FAIL drain_issue_%0d got cmd %0d addr %h want %0d %h", k, cmd, maddr, BUS_LOAD, drain_addr[k]); end
            tick(); ttag = '0; dtag = 4'(8 + k); mdata = {32'hD0000001 + 32'(k), 32'hC0000001 + 32'(k)};
            tick(); dtag = '0; #3;
            exp_resp = '{valid: 1'b1, lq_idx: drain_idx[k], data: 32'hC0000001 + 32'(k)};
            checks++; if (resp[0] !== exp_resp) begin errors++; $display("FAIL drain_resp_%0d got %h want %h", k, resp[0], exp_resp); end
            tick();
        end
    endtask

    task automatic test_dual_port_same_line();
        load(0, 3'd0, 32'h200); load(1, 3'd1, 32'h200); #3;
        checks++; if (accept !== 2'b01 || data_valid !== 2'b00) begin errors++; $display("FAIL same_line_accept got acc %b dv %b want 01 00", accept, data_valid); end
        tick(); idle(); ttag = 4'd12; #3;
        checks++; if (cmd !== BUS_LOAD || maddr !== 32'h200) begin errors++; $display("FAIL same_line_issue got cmd %0d addr %h want %0d 00000200", cmd, maddr, BUS_LOAD); end
        tick(); ttag = '0; #3;
        checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL same_line_single got %0d want %0d", cmd, BUS_NONE); end
        tick(); dtag = 4'd12; mdata = 64'h12345678_9ABCDEF0;
        tick(); dtag = '0; #3;
        exp_resp = '{valid: 1'b1, lq_idx: 3'd0, data: 32'h9ABCDEF0};
        checks++; if (resp[0] !== exp_resp) begin errors++; $display("FAIL same_line_resp got %h want %h", resp[0], exp_resp); end
        tick(); load(1, 3'd1, 32'h204); #3;
        checks++; if (data_valid !== 2'b10 || rdata[1] !== 32'h12345678) begin errors++; $display("FAIL same_line_hit got dv %b data %h want 10 12345678", data_valid, rdata[1]); end
        tick(); idle();
    endtask

    task automatic test_reset_mid_miss();
        tick(); load(0, 3'd3, 32'h238); #3;
        checks++; if (accept !== 2'b01) begin errors++; $display("FAIL rmid_accept got %b want 01", accept); end
        tick(); idle(); ttag = 4'd2; #3;
        checks++; if (cmd !== BUS_LOAD || maddr !== 32'h238) begin errors++; $display("FAIL rmid_issue got cmd %0d addr %h want %0d 00000238", cmd, maddr, BUS_LOAD); end
        tick(); ttag = '0; reset = 1'b1; #3;
        checks++; if (cmd !== BUS_NONE || resp[0].valid !== 1'b0) begin errors++; $display("FAIL rmid_in_reset got cmd %0d valid %b want %0d 0", cmd, resp[0].valid, BUS_NONE); end
        tick(); reset = 1'b0; dtag = 4'd2; mdata = 64'hFEEDFACE_CAFEBABE;
        tick(); dtag = '0; #3;
        checks++; if (resp[0].valid !== 1'b0) begin errors++; $display("FAIL rmid_stale_resp got %b want 0", resp[0].valid); end
        tick(); load(0, 3'd3, 32'h238); #3;
        checks++; if (data_valid !== 2'b00) begin errors++; $display("FAIL rmid_line_invalid got %b want 00", data_valid); end
        checks++; if (accept !== 2'b01) begin errors++; $display("FAIL rmid_realloc got %b want 01", accept); end
        tick(); idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_cold_miss();
        test_hit();
        test_backpressure();
        test_mshr_full();
        test_dual_port_same_line();
        test_reset_mid_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
